// File: rtl/prefetch_pc_gen_if.sv
// prefetch_pc_gen_if: ICache request and fetch-stage handoff bundle
interface prefetch_pc_gen_if #(parameter int FETCH_WIDTH = 2);
  logic                   icache_req;
  logic [31:0]            icache_addr;
  logic                   icache_addr_ok;
  logic                   fs_allowin;
  logic                   to_fs_valid;
  logic [31:0]            to_fs_pc;
  logic [FETCH_WIDTH-1:0] to_fs_mask;
  logic                   to_fs_ex;
  logic [31:0]            to_fs_badvaddr;
  modport master (
    output icache_req, icache_addr, to_fs_valid, to_fs_pc, to_fs_mask, to_fs_ex, to_fs_badvaddr,
    input  icache_addr_ok, fs_allowin
  );
  modport slave (
    input  icache_req, icache_addr, to_fs_valid, to_fs_pc, to_fs_mask, to_fs_ex, to_fs_badvaddr,
    output icache_addr_ok, fs_allowin
  );
endinterface

// File: rtl/prefetch_pc_gen.sv
// prefetch_pc_gen: fetch-group PC generation with branch/delay-slot, correction, flush and ADEL handling
module prefetch_pc_gen #(
  parameter int          FETCH_WIDTH = 2,
  parameter logic [31:0] RESET_PC    = 32'hbfc0_0000
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            flush,
  input  logic [31:0]                     flush_pc,
  input  logic                            bpu_valid,
  input  logic                            bpu_taken,
  input  logic [$clog2(FETCH_WIDTH)-1:0]  bpu_slot,
  input  logic [31:0]                     bpu_target,
  input  logic                            corr_valid,
  input  logic [31:0]                     corr_target,
  prefetch_pc_gen_if.master               bus
);
  localparam int SLOT_W = $clog2(FETCH_WIDTH);
  localparam int LW = SLOT_W + 2;
  localparam logic [FETCH_WIDTH-1:0] ONES = '1;
  typedef enum logic [1:0] {SEQ, DELAY, TARGET, CORR} state_t;
  state_t state, state_nxt;
  logic valid, ex, accept, bpu_take, last;
  logic [31:0] fetch_pc, tgt, corr, cur_pc, grp;
  always_ff @(posedge clk) begin
    if (reset) begin
      valid    <= 1'b0;
      state    <= SEQ;
      fetch_pc <= RESET_PC;
      tgt      <= '0;
      corr     <= '0;
    end else begin
      valid <= 1'b1;
      state <= state_nxt;
      if (flush) fetch_pc <= flush_pc;
      else if (accept && state_nxt != DELAY) fetch_pc <= grp + 32'(4 * FETCH_WIDTH);
      if (!flush && !corr_valid && state == SEQ && bpu_take) tgt <= bpu_target;
      if (!flush && corr_valid) corr <= corr_target;
    end
  end
  // SEQ->DELAY keeps fetch_pc so the group after the branch is re-issued as the delay slot
  always_comb begin
    bpu_take  = bpu_valid && bpu_taken;
    last      = bpu_slot == SLOT_W'(FETCH_WIDTH - 1);
    state_nxt = flush ? SEQ :
                corr_valid ? CORR :
                state == SEQ ? (bpu_take ? (last ? DELAY : TARGET) : SEQ) :
                !accept ? state :
                state == DELAY ? TARGET : SEQ;
  end
  always_comb begin
    cur_pc             = state == TARGET ? tgt : state == CORR ? corr : fetch_pc;
    grp                = {cur_pc[31:LW], {LW{1'b0}}};
    ex                 = valid && |cur_pc[1:0];
    bus.icache_req     = valid && bus.fs_allowin && !flush && !ex;
    bus.icache_addr    = valid ? grp : '0;
    accept             = (bus.icache_req && bus.icache_addr_ok) || (ex && bus.fs_allowin && !flush);
    bus.to_fs_valid    = accept;
    bus.to_fs_pc       = valid ? grp : '0;
    bus.to_fs_mask     = !valid ? '0 : ex ? ONES : state == DELAY ? FETCH_WIDTH'(1) : ONES << cur_pc[LW-1:2];
    bus.to_fs_ex       = ex;
    bus.to_fs_badvaddr = ex ? cur_pc : '0;
  end
endmodule

// File: tb/tb_prefetch_pc_gen.sv
// tb_prefetch_pc_gen: directed vector table plus reset sequences for prefetch_pc_gen (FETCH_WIDTH=4)
module tb_prefetch_pc_gen;
  logic clk = 1'b0, reset = 1'b1, flush = 1'b0, bpu_valid = 1'b0, bpu_taken = 1'b0, corr_valid = 1'b0;
  logic [31:0] flush_pc = '0, bpu_target = '0, corr_target = '0;
  logic [1:0] bpu_slot = '0;
  int tests = 0, fails = 0;
  prefetch_pc_gen_if #(.FETCH_WIDTH(4)) bus ();
  prefetch_pc_gen #(.FETCH_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .flush(flush), .flush_pc(flush_pc),
    .bpu_valid(bpu_valid), .bpu_taken(bpu_taken), .bpu_slot(bpu_slot), .bpu_target(bpu_target),
    .corr_valid(corr_valid), .corr_target(corr_target), .bus(bus)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic fl; logic [31:0] fpc; logic bv; logic [1:0] bs; logic [31:0] bt;
    logic cv; logic [31:0] ct; logic al, ok;
    logic req; logic [31:0] addr; logic fsv; logic [3:0] mask; logic ex; logic [31:0] bad;
  } vec_t;
  vec_t tv[$];
  function automatic vec_t mk(logic fl, logic [31:0] fpc, logic bv, logic [1:0] bs, logic [31:0] bt,
                              logic cv, logic [31:0] ct, logic al, logic ok, logic req, logic [31:0] addr,
                              logic fsv, logic [3:0] mask, logic ex, logic [31:0] bad);
    vec_t r;
    r.fl = fl; r.fpc = fpc; r.bv = bv; r.bs = bs; r.bt = bt; r.cv = cv; r.ct = ct; r.al = al; r.ok = ok;
    r.req = req; r.addr = addr; r.fsv = fsv; r.mask = mask; r.ex = ex; r.bad = bad;
    return r;
  endfunction
  function automatic vec_t go(logic [31:0] addr, logic [3:0] mask);
    return mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, addr, 1, mask, 0, 0);
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  task automatic chk_all(input string n, input logic req, input logic [31:0] addr, input logic fsv,
                         input logic [3:0] mask, input logic ex, input logic [31:0] bad, input logic [31:0] pc);
    chk({n, ".req"}, 32'(bus.icache_req), 32'(req));
    chk({n, ".addr"}, bus.icache_addr, addr);
    chk({n, ".fsv"}, 32'(bus.to_fs_valid), 32'(fsv));
    chk({n, ".mask"}, 32'(bus.to_fs_mask), 32'(mask));
    chk({n, ".ex"}, 32'(bus.to_fs_ex), 32'(ex));
    chk({n, ".bad"}, bus.to_fs_badvaddr, bad);
    chk({n, ".pc"}, bus.to_fs_pc, pc);
  endtask
  initial begin
    tv.push_back(go(32'hbfc00000, 4'hf));
    tv.push_back(go(32'hbfc00010, 4'hf));
    tv.push_back(mk(0, 0, 1, 1, 32'hbfc00104, 0, 0, 1, 1, 1, 32'hbfc00020, 1, 4'hf, 0, 0));
    tv.push_back(go(32'hbfc00100, 4'he));
    tv.push_back(go(32'hbfc00110, 4'hf));
    tv.push_back(mk(1, 32'hbfc00000, 0, 0, 0, 0, 0, 1, 1, 0, 32'hbfc00120, 0, 4'hf, 0, 0));
    tv.push_back(go(32'hbfc00000, 4'hf));
    tv.push_back(mk(0, 0, 1, 3, 32'h80000000, 0, 0, 1, 1, 1, 32'hbfc00010, 1, 4'hf, 0, 0));
    tv.push_back(go(32'hbfc00010, 4'h1));
    tv.push_back(go(32'h80000000, 4'hf));
    tv.push_back(go(32'h80000010, 4'hf));
    tv.push_back(mk(0, 0, 0, 0, 0, 1, 32'hbfc00102, 1, 1, 1, 32'h80000020, 1, 4'hf, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 32'hbfc00100, 1, 4'hf, 1, 32'hbfc00102));
    tv.push_back(go(32'hbfc00110, 4'hf));
    tv.push_back(mk(1, 32'hbfc00380, 1, 1, 32'h11111110, 1, 32'h12345678, 1, 1, 0, 32'hbfc00120, 0, 4'hf, 0, 0));
    tv.push_back(go(32'hbfc00380, 4'hf));
    tv.push_back(mk(0, 0, 1, 0, 32'hbfc00200, 0, 0, 1, 1, 1, 32'hbfc00390, 1, 4'hf, 0, 0));
    for (int k = 0; k < 3; k++) tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 32'hbfc00200, 0, 4'hf, 0, 0));
    tv.push_back(go(32'hbfc00200, 4'hf));
    tv.push_back(go(32'hbfc00210, 4'hf));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'hbfc00220, 0, 4'hf, 0, 0));
    tv.push_back(go(32'hbfc00220, 4'hf));
    tv.push_back(mk(1, 32'hfffffff0, 0, 0, 0, 0, 0, 1, 1, 0, 32'hbfc00230, 0, 4'hf, 0, 0));
    tv.push_back(go(32'hfffffff0, 4'hf));
    tv.push_back(go(32'h00000000, 4'hf));
    tv.push_back(mk(1, 32'h00000041, 0, 0, 0, 0, 0, 1, 1, 0, 32'h00000010, 0, 4'hf, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h00000040, 0, 4'hf, 1, 32'h00000041));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h00000040, 1, 4'hf, 1, 32'h00000041));
    tv.push_back(go(32'h00000050, 4'hf));
    tv.push_back(mk(1, 32'h00000108, 0, 0, 0, 0, 0, 1, 1, 0, 32'h00000060, 0, 4'hf, 0, 0));
    tv.push_back(go(32'h00000100, 4'hc));
    tv.push_back(mk(0, 0, 1, 0, 32'h00000200, 0, 0, 1, 1, 1, 32'h00000110, 1, 4'hf, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 1, 32'h00000300, 1, 0, 1, 32'h00000200, 0, 4'hf, 0, 0));
    tv.push_back(go(32'h00000300, 4'hf));
    tv.push_back(go(32'h00000310, 4'hf));
    bus.fs_allowin = 1'b1;
    bus.icache_addr_ok = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk_all("in_reset", 0, 0, 0, 4'h0, 0, 0, 0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk_all("post_reset", 0, 0, 0, 4'h0, 0, 0, 0);
    @(posedge clk); #1;
    foreach (tv[i]) begin
      flush = tv[i].fl; flush_pc = tv[i].fpc;
      bpu_valid = tv[i].bv; bpu_taken = tv[i].bv; bpu_slot = tv[i].bs; bpu_target = tv[i].bt;
      corr_valid = tv[i].cv; corr_target = tv[i].ct;
      bus.fs_allowin = tv[i].al; bus.icache_addr_ok = tv[i].ok;
      @(negedge clk);
      chk_all($sformatf("r%0d", i), tv[i].req, tv[i].addr, tv[i].fsv, tv[i].mask, tv[i].ex, tv[i].bad, tv[i].addr);
      @(posedge clk); #1;
    end
    {flush, bpu_valid, bpu_taken, corr_valid} = '0;
    bus.fs_allowin = 1'b1;
    bus.icache_addr_ok = 1'b0;
    @(negedge clk);
    chk_all("stall_pre_reset", 1, 32'h00000320, 0, 4'hf, 0, 0, 32'h00000320);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    bus.icache_addr_ok = 1'b1;
    @(negedge clk);
    chk_all("rst_mid_stall", 0, 0, 0, 4'h0, 0, 0, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk_all("rst_restart", 1, 32'hbfc00000, 1, 4'hf, 0, 0, 32'hbfc00000);
    @(posedge clk); #1;
    @(negedge clk);
    chk_all("rst_next", 1, 32'hbfc00010, 1, 4'hf, 0, 0, 32'hbfc00010);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
